hazard_pipe_ctrl: RTL and testbench

Parametrised hazard and forwarding controller for the pipelined `mips` core, sitting beside the decode stage and driving the stall/flush/select controls of `fetch`, `ifid`, `id_ex` and `execute`. It keeps an internal scoreboard of in-flight register writes, one entry per post-decode stage. From that scoreboard it produces:
- load-use and no-forwarding stalls;
- bubble insertion into ID/EX;
- IF/ID flush on a taken branch;
- registered ALU operand-forwarding selects for the instruction in EX.

It also counts stall cycles for performance measurement.

---
 rtl/hazard_pipe_ctrl.sv | 78 +++++++
 tb/tb_hazard_pipe_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_pipe_ctrl.sv
// hazard_pipe_ctrl: scoreboard-driven stall, bubble, flush and operand-forward control for a pipelined MIPS core
module hazard_pipe_ctrl #(
  parameter int RA_W     = 5,
  parameter int N_STAGES = 3,
  parameter int FWD_EN   = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_id_valid,
  input  logic [RA_W-1:0]  i_id_rs,
  input  logic [RA_W-1:0]  i_id_rt,
  input  logic             i_id_uses_rs,
  input  logic             i_id_uses_rt,
  input  logic [RA_W-1:0]  i_id_dest,
  input  logic             i_id_regwrite,
  input  logic             i_id_memread,
  input  logic             i_ex_branch_taken,
  output logic             o_stall_if,
  output logic             o_bubble_ex,
  output logic             o_flush_ifid,
  output logic [1:0]       o_fwd_a,
  output logic [1:0]       o_fwd_b,
  output logic [CNT_W-1:0] o_stall_count
);
  localparam int LOW = (1 << (N_STAGES - 1)) - 1;
  localparam logic [N_STAGES-1:0] HAZ_MASK = N_STAGES'(FWD_EN != 0 ? (LOW & ~3) : LOW);
  logic [N_STAGES-1:0]           r_v;
  logic [N_STAGES-1:0]           r_rw;
  logic [N_STAGES-1:0][RA_W-1:0] r_dst;
  logic                          r_mr0;
  logic [1:0]                    r_fwd_a;
  logic [1:0]                    r_fwd_b;
  logic [CNT_W-1:0]              r_cnt;
  logic [N_STAGES-1:0]           w_ms;
  logic [N_STAGES-1:0]           w_mt;
  logic                          w_haz;
  logic                          w_v0;
  logic [1:0]                    w_fwd_a;
  logic [1:0]                    w_fwd_b;
  for (genvar g = 0; g < N_STAGES; g++) begin : g_match
    assign w_ms[g] = r_v[g] & r_rw[g] & (r_dst[g] != '0) & (r_dst[g] == i_id_rs) & i_id_uses_rs;
    assign w_mt[g] = r_v[g] & r_rw[g] & (r_dst[g] != '0) & (r_dst[g] == i_id_rt) & i_id_uses_rt;
  end
  assign w_haz = i_id_valid & ((|((w_ms | w_mt) & HAZ_MASK)) | ((FWD_EN != 0) & r_mr0 & (w_ms[0] | w_mt[0])));
  // Same-cycle pipeline controls; a taken branch overrides any stall
  always_comb begin
    o_flush_ifid = ~rst & i_ex_branch_taken;
    o_stall_if   = ~rst & w_haz & ~i_ex_branch_taken;
    o_bubble_ex  = ~rst & (w_haz | i_ex_branch_taken);
    w_v0         = i_id_valid & ~o_bubble_ex;
    w_fwd_a      = (!w_v0 || FWD_EN == 0) ? 2'b00 : w_ms[0] ? 2'b01 : w_ms[1] ? 2'b10 : 2'b00;
    w_fwd_b      = (!w_v0 || FWD_EN == 0) ? 2'b00 : w_mt[0] ? 2'b01 : w_mt[1] ? 2'b10 : 2'b00;
  end
  // Scoreboard shift, forward-select registers and saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v     <= '0;
      r_rw    <= '0;
      r_dst   <= '0;
      r_mr0   <= 1'b0;
      r_fwd_a <= 2'b00;
      r_fwd_b <= 2'b00;
      r_cnt   <= '0;
    end else begin
      r_v     <= {r_v[N_STAGES-2:0], w_v0};
      r_rw    <= {r_rw[N_STAGES-2:0], w_v0 & i_id_regwrite};
      r_dst   <= {r_dst[N_STAGES-2:0], {RA_W{w_v0}} & i_id_dest};
      r_mr0   <= w_v0 & i_id_memread;
      r_fwd_a <= w_fwd_a;
      r_fwd_b <= w_fwd_b;
      r_cnt   <= r_cnt + CNT_W'(o_stall_if && !(&r_cnt));
    end
  end
  assign o_fwd_a       = r_fwd_a;
  assign o_fwd_b       = r_fwd_b;
  assign o_stall_count = r_cnt;
endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// tb_hazard_pipe_ctrl: three configurations driven by one directed stream, checked against an instruction-age model
module tb_hazard_pipe_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, v = 1'b0, urs = 1'b0, urt = 1'b0, rw = 1'b0, mr = 1'b0, br = 1'b0;
  logic [4:0] rs = '0, rt = '0, dst = '0;
  logic [2:0] st, bu, fl;
  logic [2:0][1:0] fa, fb;
  logic [15:0] ca, cc;
  logic [1:0] cb;
  int checks = 0, fails = 0;
  logic started = 1'b0;
  typedef struct packed {logic v; logic rw; logic mr; logic [4:0] d;} ent_t;
  ent_t h[3][8];
  int mcnt[3], mfa[3], mfb[3];

  hazard_pipe_ctrl #(.RA_W(5), .N_STAGES(3), .FWD_EN(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .i_id_valid(v), .i_id_rs(rs), .i_id_rt(rt), .i_id_uses_rs(urs),
    .i_id_uses_rt(urt), .i_id_dest(dst), .i_id_regwrite(rw), .i_id_memread(mr),
    .i_ex_branch_taken(br), .o_stall_if(st[0]), .o_bubble_ex(bu[0]), .o_flush_ifid(fl[0]),
    .o_fwd_a(fa[0]), .o_fwd_b(fb[0]), .o_stall_count(ca));
  hazard_pipe_ctrl #(.RA_W(5), .N_STAGES(3), .FWD_EN(0), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .i_id_valid(v), .i_id_rs(rs), .i_id_rt(rt), .i_id_uses_rs(urs),
    .i_id_uses_rt(urt), .i_id_dest(dst), .i_id_regwrite(rw), .i_id_memread(mr),
    .i_ex_branch_taken(br), .o_stall_if(st[1]), .o_bubble_ex(bu[1]), .o_flush_ifid(fl[1]),
    .o_fwd_a(fa[1]), .o_fwd_b(fb[1]), .o_stall_count(cb));
  hazard_pipe_ctrl #(.RA_W(5), .N_STAGES(4), .FWD_EN(1), .CNT_W(16)) u_c (
    .clk(clk), .rst(rst), .i_id_valid(v), .i_id_rs(rs), .i_id_rt(rt), .i_id_uses_rs(urs),
    .i_id_uses_rt(urt), .i_id_dest(dst), .i_id_regwrite(rw), .i_id_memread(mr),
    .i_ex_branch_taken(br), .o_stall_if(st[2]), .o_bubble_ex(bu[2]), .o_flush_ifid(fl[2]),
    .o_fwd_a(fa[2]), .o_fwd_b(fb[2]), .o_stall_count(cc));

  function automatic int ns(int i);
    return i == 2 ? 4 : 3;
  endfunction
  function automatic int fw(int i);
    return i == 1 ? 0 : 1;
  endfunction
  function automatic int cmax(int i);
    return i == 1 ? 3 : 65535;
  endfunction
  function automatic int dut_cnt(int i);
    return i == 0 ? int'(ca) : i == 1 ? int'(cb) : int'(cc);
  endfunction
  // producer issued k cycles ago writes register r that the decode instruction reads
  function automatic logic hit(int i, int k, logic [4:0] r, logic u);
    return h[i][k].v && h[i][k].rw && h[i][k].d != 0 && h[i][k].d == r && u;
  endfunction
  // a dependence is fine only if its result can reach EX in time
  function automatic logic haz(int i);
    for (int k = 0; k < ns(i); k++)
      if ((hit(i, k, rs, urs) || hit(i, k, rt, urt)) &&
          !(k == ns(i) - 1 || (fw(i) == 1 && (k == 1 || (k == 0 && !h[i][k].mr)))))
        return 1'b1;
    return 1'b0;
  endfunction
  function automatic logic e_stall(int i);
    return !rst && v && haz(i) && !br;
  endfunction
  function automatic logic e_bub(int i);
    return !rst && ((v && haz(i)) || br);
  endfunction
  function automatic int e_fwd(int i, logic [4:0] r, logic u);
    if (e_bub(i) || !v || fw(i) == 0) return 0;
    return hit(i, 0, r, u) ? 1 : hit(i, 1, r, u) ? 2 : 0;
  endfunction
  function automatic ent_t newent(int i);
    return (e_bub(i) || !v) ? '0 : {1'b1, rw, mr, dst};
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        for (int k = 0; k < 8; k++) h[i][k] <= '0;
        mcnt[i] <= 0;
        mfa[i] <= 0;
        mfb[i] <= 0;
      end else begin
        mcnt[i] <= (e_stall(i) && mcnt[i] < cmax(i)) ? mcnt[i] + 1 : mcnt[i];
        mfa[i] <= e_fwd(i, rs, urs);
        mfb[i] <= e_fwd(i, rt, urt);
        for (int k = 7; k > 0; k--) h[i][k] <= h[i][k-1];
        h[i][0] <= newent(i);
      end
    end
    started <= 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("stall_if[%0d]", i), 32'(st[i]), 32'(e_stall(i)));
        chk($sformatf("bubble_ex[%0d]", i), 32'(bu[i]), 32'(e_bub(i)));
        chk($sformatf("flush_ifid[%0d]", i), 32'(fl[i]), 32'(!rst && br));
        chk($sformatf("fwd_a[%0d]", i), 32'(fa[i]), mfa[i]);
        chk($sformatf("fwd_b[%0d]", i), 32'(fb[i]), mfb[i]);
        chk($sformatf("stall_count[%0d]", i), dut_cnt(i), mcnt[i]);
      end
    end
  end

  task automatic step(input logic r, input logic iv, input logic [4:0] irs, input logic [4:0] irt,
                      input logic iurs, input logic iurt, input logic [4:0] id, input logic irw,
                      input logic imr, input logic ibr);
    @(posedge clk);
    #2;
    rst = r; v = iv; rs = irs; rt = irt; urs = iurs; urt = iurt; dst = id; rw = irw; mr = imr; br = ibr;
    @(negedge clk);
  endtask
  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic alu(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    step(0, 1, s, t, 1, 1, d, 1, 0, 0);
  endtask
  task automatic lw(input logic [4:0] d, input logic [4:0] base);
    step(0, 1, base, 0, 1, 0, d, 1, 1, 0);
  endtask

  initial begin
    for (int n = 0; n < 2; n++) begin
      step(1, 1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom));
      chk("rst stall", 32'(st), 0);
      chk("rst bubble", 32'(bu), 0);
      chk("rst flush", 32'(fl), 0);
    end
    chk("rst count", 32'(ca), 0);
    chk("rst fwd", 32'(fa[0]), 0);
    nop();
    chk("idle stall", 32'(st[0]), 0);
    lw(8, 29);
    alu(9, 8, 8);
    chk("lu stall", 32'(st[0]), 1);
    chk("lu bubble", 32'(bu[0]), 1);
    alu(9, 8, 8);
    chk("lu released", 32'(st[0]), 0);
    chk("lu count", 32'(ca), 1);
    nop();
    chk("lu fwd_a", 32'(fa[0]), 2);
    chk("lu fwd_b", 32'(fb[0]), 2);
    nop();
    nop();
    alu(8, 1, 2);
    alu(10, 8, 2);
    chk("alu no stall", 32'(st[0]), 0);
    nop();
    chk("alu fwd_a", 32'(fa[0]), 1);
    chk("alu fwd_b", 32'(fb[0]), 0);
    alu(8, 1, 2);
    alu(11, 3, 4);
    alu(10, 8, 2);
    nop();
    chk("wb fwd_a", 32'(fa[0]), 2);
    alu(0, 1, 0);
    alu(12, 0, 0);
    chk("r0 stall A", 32'(st[0]), 0);
    chk("r0 stall B", 32'(st[1]), 0);
    nop();
    chk("r0 fwd_a", 32'(fa[0]), 0);
    chk("r0 fwd_b", 32'(fb[0]), 0);
    lw(8, 29);
    step(0, 1, 8, 8, 1, 1, 9, 1, 0, 1);
    chk("br flush", 32'(fl[0]), 1);
    chk("br bubble", 32'(bu[0]), 1);
    chk("br stall", 32'(st[0]), 0);
    nop();
    chk("br count", 32'(ca), 1);
    nop();
    nop();
    alu(8, 1, 2);
    nop();
    nop();
    alu(13, 8, 3);
    chk("stage2 stall C", 32'(st[2]), 1);
    chk("stage2 stall A", 32'(st[0]), 0);
    chk("stage2 stall B", 32'(st[1]), 0);
    alu(13, 8, 3);
    chk("stage2 released C", 32'(st[2]), 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop();
    chk("nofwd reset cnt", 32'(cb), 0);
    alu(8, 1, 2);
    alu(13, 8, 3);
    chk("nofwd stall 1", 32'(st[1]), 1);
    alu(13, 8, 3);
    chk("nofwd stall 2", 32'(st[1]), 1);
    alu(13, 8, 3);
    chk("nofwd stall 3", 32'(st[1]), 0);
    nop();
    chk("nofwd count", 32'(cb), 2);
    for (int n = 0; n < 2; n++) begin
      alu(8, 1, 2);
      for (int m = 0; m < 3; m++) alu(13, 8, 3);
      nop();
      chk("sat count", 32'(cb), 3);
    end
    alu(8, 1, 2);
    alu(13, 8, 3);
    chk("mid stall", 32'(st[1]), 1);
    step(1, 1, 8, 3, 1, 1, 13, 1, 0, 0);
    chk("mid rst stall", 32'(st[1]), 0);
    step(0, 1, 8, 3, 1, 1, 13, 1, 0, 0);
    chk("post rst stall", 32'(st[1]), 0);
    chk("post rst count", 32'(cb), 0);
    nop();
    nop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
